// File: rtl/fusion_pe_acc.sv
// rtl/fusion_pe_acc.sv - bit-fusion PE with runtime precision and grouped accumulation
//
// Multiplies an activation byte by a weight byte as one 8x8 product, two 4x4
// nibble products or four 2x2 bit-pair products. Each field is independently
// signed or unsigned. Beats are accumulated together with the forwarded partial
// sum, and one result is emitted per accumulation group.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream beat handshake
//   act, weight           operand bytes
//   psum_in               forwarded partial sum, added on every beat
//   s_in, s_weight        signedness of activation / weight fields
//   mode                  00 8x8, 01 2x 4x4, 10 4x 2x2, 11 same as 00
//   acc_last              final beat of an accumulation group
//   acc_clear             synchronous flush of all in-flight state
//   out_valid / out_ready downstream result handshake
//   psum_out              group result
module fusion_pe_acc #(
   parameter int COL_WIDTH = 11,
   parameter int DATA_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      act,
   input  logic [DATA_W-1:0]      weight,
   input  logic [2*COL_WIDTH-1:0] psum_in,
   input  logic                   s_in,
   input  logic                   s_weight,
   input  logic [1:0]             mode,
   input  logic                   acc_last,
   input  logic                   acc_clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*COL_WIDTH-1:0] psum_out
);

   localparam int PW = 2 * COL_WIDTH;

   generate
      if (DATA_W != 8) begin : g_bad_data_w
         $error("fusion_pe_acc: DATA_W must be 8");
      end
      if (PW <= 18) begin : g_bad_col_width
         $error("fusion_pe_acc: 2*COL_WIDTH must exceed the 18-bit field product");
      end
   endgenerate

   // Field extension to a common 9-bit signed operand.
   function automatic logic signed [8:0] ext8(input logic [7:0] f, input logic s);
      return {s & f[7], f};
   endfunction

   function automatic logic signed [8:0] ext4(input logic [3:0] f, input logic s);
      return {{5{s & f[3]}}, f};
   endfunction

   function automatic logic signed [8:0] ext2(input logic [1:0] f, input logic s);
      return {{7{s & f[1]}}, f};
   endfunction

   // Signed 18-bit field product, sign-extended to the psum width.
   function automatic logic [PW-1:0] fprod(input logic signed [8:0] a,
                                          input logic signed [8:0] b);
      logic signed [17:0] p;
      p = 18'(a) * 18'(b);
      return {{(PW-18){p[17]}}, p};
   endfunction

   logic [PW-1:0] prod_sum;

   always_comb begin
      prod_sum = '0;
      case (mode)
         2'b01: begin
            prod_sum = fprod(ext4(act[3:0], s_in), ext4(weight[3:0], s_weight))
                     + fprod(ext4(act[7:4], s_in), ext4(weight[7:4], s_weight));
         end
         2'b10: begin
            prod_sum = fprod(ext2(act[1:0], s_in), ext2(weight[1:0], s_weight))
                     + fprod(ext2(act[3:2], s_in), ext2(weight[3:2], s_weight))
                     + fprod(ext2(act[5:4], s_in), ext2(weight[5:4], s_weight))
                     + fprod(ext2(act[7:6], s_in), ext2(weight[7:6], s_weight));
         end
         default: begin
            prod_sum = fprod(ext8(act, s_in), ext8(weight, s_weight));
         end
      endcase
   end

   logic          s1_valid;
   logic          s1_last;
   logic [PW-1:0] s1_prod;
   logic [PW-1:0] s1_psum;
   logic [PW-1:0] acc;
   logic [PW-1:0] grp_sum;
   logic          s2_take;
   logic          beat_xfer;

   // Stage 2 may consume when the output slot is empty or being drained.
   assign s2_take   = s1_valid && (!out_valid || out_ready);
   assign in_ready  = !acc_clear && (!s1_valid || s2_take);
   assign beat_xfer = in_valid && in_ready;
   assign grp_sum   = acc + s1_prod + s1_psum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_prod   <= '0;
         s1_psum   <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         psum_out  <= '0;
      end else if (acc_clear) begin
         s1_valid  <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (beat_xfer) begin
            s1_valid <= 1'b1;
            s1_prod  <= prod_sum;
            s1_psum  <= psum_in;
            s1_last  <= acc_last;
         end else if (s2_take) begin
            s1_valid <= 1'b0;
         end

         // A new group result overrides the drain of the old one.
         if (s2_take && s1_last) begin
            psum_out  <= grp_sum;
            out_valid <= 1'b1;
            acc       <= '0;
         end else begin
            if (s2_take) begin
               acc <= grp_sum;
            end
            if (out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
